// File: rtl/trdb_pkg.sv
// Shared constants, state type and sizing helper for the trace stream packer/deframer pair.
package trdb_pkg;

  localparam int unsigned PACKET_HEADER_LEN = 7;
  localparam int unsigned PACKET_LEN        = 64;
  localparam int unsigned DEFRAME_CAP_BYTES = (PACKET_LEN + PACKET_HEADER_LEN + 7) / 8 + 4;

  typedef enum logic [1:0] {HDR, BODY, OUT} trdb_deframe_state_e;

  // Bytes occupied by a packet of len payload bits plus its length header.
  function automatic int unsigned trdb_pkt_bytes(input int unsigned len,
                                                 input int unsigned hdr_len = PACKET_HEADER_LEN);
    return (len + hdr_len + 7) / 8;
  endfunction

endpackage

// File: rtl/trdb_stream_deframe8_if.sv
// Word-stream input and packet output bundle of the trace deframer.
interface trdb_stream_deframe8_if #(
  parameter int unsigned HDR_LEN = trdb_pkg::PACKET_HEADER_LEN,
  parameter int unsigned PLD_LEN = trdb_pkg::PACKET_LEN
);
  logic [31:0]        data_i;
  logic               valid_i;
  logic               ready_o;
  logic               clear_i;
  logic [PLD_LEN-1:0] packet_bits_o;
  logic [HDR_LEN-1:0] packet_len_o;
  logic               valid_o;
  logic               grant_i;
  logic               error_o;

  modport slave (
    input  data_i, valid_i, clear_i, grant_i,
    output ready_o, packet_bits_o, packet_len_o, valid_o, error_o
  );

  modport master (
    output data_i, valid_i, clear_i, grant_i,
    input  ready_o, packet_bits_o, packet_len_o, valid_o, error_o
  );
endinterface

// File: rtl/trdb_byte_fifo_shift.sv
// Byte-granular shift buffer: 4-byte push at the tail, 0..CAP byte pop from the head, flat view out.
module trdb_byte_fifo_shift #(
  parameter int unsigned CAP  = trdb_pkg::DEFRAME_CAP_BYTES,
  parameter int unsigned CNTW = $clog2(CAP + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [31:0]      data_i,
  input  logic [CNTW-1:0]  pop_i,
  output logic [CNTW-1:0]  cnt_o,
  output logic [8*CAP-1:0] flat_o
);

  logic [8*CAP-1:0] flat_q, flat_d, kept, word_ext;
  logic [CNTW-1:0]  cnt_q, cnt_d, kept_cnt;

  assign word_ext = {{(8*CAP-32){1'b0}}, data_i};

  // Pop first, then append behind what remains; bytes above cnt_q are always zero.
  always_comb begin
    kept     = flat_q >> {pop_i, 3'b000};
    kept_cnt = cnt_q - pop_i;
    flat_d   = kept;
    cnt_d    = kept_cnt;
    if (push_i) begin
      flat_d = kept | (word_ext << {kept_cnt, 3'b000});
      cnt_d  = kept_cnt + CNTW'(4);
    end
    if (clear_i) begin
      flat_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flat_q <= '0;
      cnt_q  <= '0;
    end else begin
      flat_q <= flat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign flat_o = flat_q;

endmodule

// File: rtl/trdb_stream_deframe8.sv
// Rebuilds {payload, length} trace packets from a byte-packed 32-bit word stream.
// Define TRDB_DEFRAME_ERR_EN to enable the sticky over-length error check.
module trdb_stream_deframe8
  import trdb_pkg::*;
#(
  parameter int unsigned HDR_LEN = PACKET_HEADER_LEN,
  parameter int unsigned PLD_LEN = PACKET_LEN,
  parameter int unsigned ID      = 1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  trdb_stream_deframe8_if.slave bus
);

  localparam int unsigned     CAP      = trdb_pkt_bytes(PLD_LEN, HDR_LEN) + 4;
  localparam int unsigned     CNTW     = $clog2(CAP + 1);
  localparam logic [CNTW-1:0] HdrBytes = CNTW'((HDR_LEN + 7) / 8);
  localparam logic [CNTW-1:0] MaxBytes = CNTW'(CAP - 4);

  trdb_deframe_state_e state_q, state_d;
  logic [1:0]          align_q, align_d;
  logic                valid_q, valid_d;
  logic [PLD_LEN-1:0]  bits_q, bits_d;
  logic [HDR_LEN-1:0]  len_q, len_d;
  logic [CNTW-1:0]     cnt, pop, nbytes;
  logic [8*CAP-1:0]    flat;
  logic [HDR_LEN-1:0]  head_len;
  logic [31:0]         nb_raw;
  logic [PLD_LEN-1:0]  mask;
  logic                ready, push, flush;
`ifdef TRDB_DEFRAME_ERR_EN
  logic                err_q, err_d;
`endif

  trdb_byte_fifo_shift #(.CAP(CAP), .CNTW(CNTW)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (bus.data_i),
    .pop_i   (pop),
    .cnt_o   (cnt),
    .flat_o  (flat)
  );

  assign head_len = flat[HDR_LEN-1:0];
  assign nb_raw   = trdb_pkt_bytes(32'(head_len), HDR_LEN);
  assign nbytes   = (nb_raw > CAP - 4) ? MaxBytes : CNTW'(nb_raw);
  assign mask     = ~({PLD_LEN{1'b1}} << head_len);
  assign ready    = (cnt <= MaxBytes);
  assign push     = bus.valid_i & ready & ~flush;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    bits_d  = bits_q;
    len_d   = len_q;
    pop     = '0;
    flush   = bus.clear_i;
`ifdef TRDB_DEFRAME_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      HDR: if (cnt >= HdrBytes) begin
        // A zero header is flush padding running to the end of its source word.
        if (head_len == '0) begin
          pop = CNTW'(3'd4 - {1'b0, align_q});
`ifdef TRDB_DEFRAME_ERR_EN
        end else if (32'(head_len) > PLD_LEN) begin
          err_d = 1'b1;
          flush = 1'b1;
`endif
        end else begin
          state_d = BODY;
        end
      end
      BODY: if (cnt >= nbytes) begin
        bits_d  = flat[HDR_LEN +: PLD_LEN] & mask;
        len_d   = head_len;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: if (bus.grant_i) begin
        pop     = nbytes;
        valid_d = 1'b0;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
    align_d = align_q + pop[1:0];
    if (flush) begin
      state_d = HDR;
      valid_d = 1'b0;
      pop     = '0;
      align_d = '0;
    end
`ifdef TRDB_DEFRAME_ERR_EN
    if (bus.clear_i) err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HDR;
      align_q <= '0;
      valid_q <= 1'b0;
      bits_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      align_q <= align_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
    end
  end

`ifdef TRDB_DEFRAME_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign bus.error_o = err_q;
`else
  assign bus.error_o = 1'b0;
`endif

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid_q;
  assign bus.packet_bits_o = bits_q;
  assign bus.packet_len_o  = len_q;

  logic unused_ok;
  assign unused_ok = ^{flat[8*CAP-1:HDR_LEN+PLD_LEN], ID != 0};

endmodule

// File: tb/tb_trdb_stream_deframe8.sv
// Directed and randomized bench for trdb_stream_deframe8 against a packet-level packer model.
module tb_trdb_stream_deframe8;

  localparam int unsigned HDR = trdb_pkg::PACKET_HEADER_LEN;
  localparam int unsigned PLD = trdb_pkg::PACKET_LEN;
  localparam int unsigned CAP = (PLD + HDR + 7) / 8 + 4;

  typedef struct {
    logic [HDR-1:0] len;
    logic [PLD-1:0] bits;
  } pkt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trdb_stream_deframe8_if #(.HDR_LEN(HDR), .PLD_LEN(PLD)) bus ();

  trdb_stream_deframe8 #(.HDR_LEN(HDR), .PLD_LEN(PLD), .ID(1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [7:0]  bytes_q[$];
  logic [31:0] words_q[$];
  pkt_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PLD-1:0] rnd_pl();
    return PLD'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Packer model: {payload, len} little-endian bytes, payload zeroed above len.
  task automatic add_pkt(input int unsigned len, input logic [PLD-1:0] pl);
    logic [PLD-1:0]     m;
    logic [PLD+HDR+7:0] frame;
    int unsigned        nb;
    m     = (len >= PLD) ? '1 : ((PLD'(1) << len) - PLD'(1));
    frame = '0;
    frame[PLD+HDR-1:0] = {pl & m, HDR'(len)};
    nb    = (len + HDR + 7) / 8;
    for (int unsigned i = 0; i < nb; i++) bytes_q.push_back(frame[8*i +: 8]);
    exp_q.push_back('{len: HDR'(len), bits: pl & m});
  endtask

  task automatic emit_words(input bit flush);
    if (flush) while (bytes_q.size() % 4 != 0) bytes_q.push_back(8'h00);
    while (bytes_q.size() >= 4) begin
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = bytes_q.pop_front();
      words_q.push_back(w);
    end
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.grant_i = 1'b0;
      bus.clear_i = 1'b0;
      chk(tag, 128'(bus.valid_o), 128'(0));
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int unsigned t = 0;
    @(negedge clk);
    while (!bus.ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 128'(bus.ready_o), 128'(1));
    bus.data_i  = w;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned max, input string tag);
    int unsigned t = 0;
    while (!bus.valid_o && t < max) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 128'(bus.valid_o), 128'(1));
  endtask

  // Streams words_q, checks every presented packet against exp_q, grants randomly.
  task automatic run(input int unsigned max, input int unsigned gnt_pct, input int unsigned vld_pct);
    int unsigned cyc = 0;
    bit          granted = 1'b0;
    while (cyc < max && (words_q.size() != 0 || exp_q.size() != 0 || bus.valid_o)) begin
      @(negedge clk);
      cyc++;
      bus.valid_i = 1'b0;
      bus.grant_i = 1'b0;
      if (granted) chk("gap", 128'(bus.valid_o), 128'(0));
      granted = 1'b0;
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 128'(bus.valid_o), 128'(0));
        end else begin
          chk("pkt_len", 128'(bus.packet_len_o), 128'(exp_q[0].len));
          chk("pkt_bits", 128'(bus.packet_bits_o), 128'(exp_q[0].bits));
          if ($urandom_range(99) < gnt_pct) begin
            bus.grant_i = 1'b1;
            void'(exp_q.pop_front());
            granted = 1'b1;
          end
        end
      end
      if (words_q.size() != 0 && $urandom_range(99) < vld_pct) begin
        bus.valid_i = 1'b1;
        bus.data_i  = words_q[0];
        if (bus.ready_o) void'(words_q.pop_front());
      end
    end
    chk("drain", 128'(words_q.size() + exp_q.size()), 128'(0));
  endtask

  initial begin
    int unsigned acc;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.grant_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(bus.ready_o), 128'(1));
    chk("rst_valid", 128'(bus.valid_o), 128'(0));
    chk("rst_bits", 128'(bus.packet_bits_o), 128'(0));
    chk("rst_len", 128'(bus.packet_len_o), 128'(0));
    chk("rst_error", 128'(bus.error_o), 128'(0));

    // Single-word packet
    words_q.push_back(32'hABCDEF19);
    exp_q.push_back('{len: HDR'(25), bits: PLD'(32'h1579BDE)});
    run(200, 100, 100);
    idle(6, "t1_idle");
    chk("t1_ready", 128'(bus.ready_o), 128'(1));

    // Two packets in one word, grant held high
    words_q.push_back(32'h12891289);
    repeat (2) exp_q.push_back('{len: HDR'(9), bits: PLD'(32'h25)});
    run(200, 100, 100);
    idle(6, "t2_idle");

    // Padding after a packet at align 2, then a fresh word from align 0
    words_q.push_back(32'h00001289);
    words_q.push_back(32'hABCDEF19);
    exp_q.push_back('{len: HDR'(9), bits: PLD'(32'h25)});
    exp_q.push_back('{len: HDR'(25), bits: PLD'(32'h1579BDE)});
    run(200, 100, 100);
    idle(6, "t3_idle");

    // Packets crossing word boundaries at various alignments
    add_pkt(17, rnd_pl());
    add_pkt(33, rnd_pl());
    add_pkt(9, rnd_pl());
    emit_words(1'b1);
    add_pkt(3, rnd_pl());
    add_pkt(PLD, rnd_pl());
    emit_words(1'b1);
    run(400, 50, 70);
    idle(6, "t4_idle");

    // Back-pressure with grant held low
    for (int i = 0; i < 6; i++) add_pkt(25, rnd_pl());
    emit_words(1'b1);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.grant_i = 1'b0;
      bus.valid_i = 1'b0;
      if (bus.valid_o) begin
        chk("bp_len", 128'(bus.packet_len_o), 128'(exp_q[0].len));
        chk("bp_bits", 128'(bus.packet_bits_o), 128'(exp_q[0].bits));
      end
      if (words_q.size() != 0) begin
        bus.valid_i = 1'b1;
        bus.data_i  = words_q[0];
        if (bus.ready_o) begin
          void'(words_q.pop_front());
          acc++;
        end
      end
    end
    chk("bp_accepted", 128'(acc), 128'((CAP - 4) / 4 + 1));
    chk("bp_ready", 128'(bus.ready_o), 128'(0));
    run(400, 100, 100);
    idle(6, "bp_idle");

    // clear_i while a long packet waits in BODY, with a concurrent word and grant
    add_pkt(60, rnd_pl());
    emit_words(1'b1);
    exp_q.delete();
    send_word(words_q[0]);
    words_q.delete();
    idle(3, "clr_body_wait");
    @(negedge clk);
    bus.clear_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h12891289;
    bus.grant_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.grant_i = 1'b0;
    chk("clr_body_valid", 128'(bus.valid_o), 128'(0));
    chk("clr_body_ready", 128'(bus.ready_o), 128'(1));
    words_q.push_back(32'hABCDEF19);
    exp_q.push_back('{len: HDR'(25), bits: PLD'(32'h1579BDE)});
    run(200, 100, 100);
    idle(6, "clr_body_idle");

    // clear_i while a packet is presented
    send_word(32'hABCDEF19);
    wait_valid(20, "clr_out_wait");
    bus.clear_i = 1'b1;
    bus.grant_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    bus.grant_i = 1'b0;
    chk("clr_out_valid", 128'(bus.valid_o), 128'(0));
    words_q.push_back(32'h12891289);
    repeat (2) exp_q.push_back('{len: HDR'(9), bits: PLD'(32'h25)});
    run(200, 100, 100);
    idle(6, "clr_out_idle");

    // Randomized packet stream with flushes and idle words
    for (int k = 0; k < 300; k++) begin
      add_pkt($urandom_range(PLD, 1), rnd_pl());
      if ($urandom_range(3) == 0) begin
        emit_words(1'b1);
        if ($urandom_range(2) == 0) words_q.push_back(32'h0);
      end else begin
        emit_words(1'b0);
      end
    end
    emit_words(1'b1);
    run(20000, 60, 75);
    idle(6, "rand_idle");

`ifdef TRDB_DEFRAME_ERR_EN
    send_word(32'(PLD + 1));
    idle(3, "err_novalid");
    chk("err_set", 128'(bus.error_o), 128'(1));
    idle(3, "err_hold");
    chk("err_sticky", 128'(bus.error_o), 128'(1));
    chk("err_ready", 128'(bus.ready_o), 128'(1));
    @(negedge clk);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
`endif
    chk("final_error", 128'(bus.error_o), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
